// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store initiator.
// Build option: define LSU_MISALIGN_EN to split misaligned H/W accesses.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size in bytes from funct3[1:0].
    function automatic logic [2:0] size_decode(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the addressed bytes out of {word1, word0}
// and sign- or zero-extends them according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word0,
    input  logic [31:0] i_word1,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = 32'({i_word1, i_word0} >> {i_off, 3'b000});

    always_comb begin
        o_data = w_shifted;
        case (i_funct3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_data = {24'b0, w_shifted[7:0]};
            F3_HU:   o_data = {16'b0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: one core request becomes one (or, with LSU_MISALIGN_EN,
// two) word-aligned memory transactions; returns extended load data.
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output state_t                o_dbg_state
);

    state_t                r_state, w_nxt_state;
    logic [2:0]            r_funct3, w_nxt_funct3;
    logic [1:0]            r_off, w_nxt_off;
    logic                  r_mem_req, w_nxt_mem_req;
    logic                  r_mem_we, w_nxt_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_nxt_mem_addr;
    logic [3:0]            r_mem_be, w_nxt_mem_be;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_nxt_mem_wdata;
    logic                  r_resp_valid, w_nxt_resp_valid;
    logic                  r_resp_err, w_nxt_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata, w_nxt_resp_rdata;

    logic [2:0]            w_size;
    logic [1:0]            w_off;
    logic [7:0]            w_be8;
    logic                  w_err_req;
    logic [DATA_WIDTH-1:0] w_wdata0;
    logic [DATA_WIDTH-1:0] w_al_word0, w_al_word1, w_load_data;

    // Lane mask spans two words: [3:0] for the first access, [7:4] for the spill.
    assign w_size   = size_decode(req_funct3[1:0]);
    assign w_off    = req_addr[1:0];
    assign w_be8    = ((8'd1 << w_size) - 8'd1) << w_off;
    assign w_wdata0 = req_wdata << {w_off, 3'b000};

`ifdef LSU_MISALIGN_EN
    logic [3:0]            r_be1, w_nxt_be1;
    logic [DATA_WIDTH-1:0] r_wdata1, w_nxt_wdata1;
    logic [DATA_WIDTH-1:0] r_word0, w_nxt_word0;
    logic [DATA_WIDTH-1:0] w_wdata1;

    assign w_wdata1   = req_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
    assign w_err_req  = !f3_legal(req_funct3, req_we);
    assign w_al_word0 = (r_state == ST_WAIT1) ? r_word0 : mem_rdata;
    assign w_al_word1 = mem_rdata;
`else
    assign w_err_req  = !f3_legal(req_funct3, req_we) || (|w_be8[7:4]);
    assign w_al_word0 = mem_rdata;
    assign w_al_word1 = '0;
`endif

    lsu_load_align u_align (
        .i_word0  (w_al_word0),
        .i_word1  (w_al_word1),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_funct3     = r_funct3;
        w_nxt_off        = r_off;
        w_nxt_mem_req    = r_mem_req;
        w_nxt_mem_we     = r_mem_we;
        w_nxt_mem_addr   = r_mem_addr;
        w_nxt_mem_be     = r_mem_be;
        w_nxt_mem_wdata  = r_mem_wdata;
        w_nxt_resp_valid = 1'b0;
        w_nxt_resp_err   = r_resp_err;
        w_nxt_resp_rdata = r_resp_rdata;
`ifdef LSU_MISALIGN_EN
        w_nxt_be1        = r_be1;
        w_nxt_wdata1     = r_wdata1;
        w_nxt_word0      = r_word0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_nxt_funct3 = req_funct3;
                    w_nxt_off    = w_off;
`ifdef LSU_MISALIGN_EN
                    w_nxt_be1    = w_be8[7:4];
                    w_nxt_wdata1 = w_wdata1;
`endif
                    if (w_err_req) begin
                        w_nxt_state      = ST_RESP;
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_resp_err   = 1'b1;
                        w_nxt_resp_rdata = '0;
                    end else begin
                        w_nxt_state     = ST_REQ0;
                        w_nxt_mem_req   = 1'b1;
                        w_nxt_mem_we    = req_we;
                        w_nxt_mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_nxt_mem_be    = w_be8[3:0];
                        w_nxt_mem_wdata = w_wdata0;
                    end
                end
            end
            ST_REQ0: begin
                if (mem_gnt) begin
                    w_nxt_mem_req = 1'b0;
                    w_nxt_state   = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
                    if (r_be1 != 4'b0000) begin
                        w_nxt_word0     = mem_rdata;
                        w_nxt_state     = ST_REQ1;
                        w_nxt_mem_req   = 1'b1;
                        w_nxt_mem_addr  = r_mem_addr + ADDR_WIDTH'(4);
                        w_nxt_mem_be    = r_be1;
                        w_nxt_mem_wdata = r_wdata1;
                    end else
`endif
                    begin
                        w_nxt_state      = ST_RESP;
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_resp_err   = 1'b0;
                        w_nxt_resp_rdata = r_mem_we ? '0 : w_load_data;
                    end
                end
            end
`ifdef LSU_MISALIGN_EN
            ST_REQ1: begin
                if (mem_gnt) begin
                    w_nxt_mem_req = 1'b0;
                    w_nxt_state   = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (mem_rvalid) begin
                    w_nxt_state      = ST_RESP;
                    w_nxt_resp_valid = 1'b1;
                    w_nxt_resp_err   = 1'b0;
                    w_nxt_resp_rdata = r_mem_we ? '0 : w_load_data;
                end
            end
`endif
            ST_RESP: w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_funct3     <= '0;
            r_off        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
`ifdef LSU_MISALIGN_EN
            r_be1        <= '0;
            r_wdata1     <= '0;
            r_word0      <= '0;
`endif
        end else begin
            r_state      <= w_nxt_state;
            r_funct3     <= w_nxt_funct3;
            r_off        <= w_nxt_off;
            r_mem_req    <= w_nxt_mem_req;
            r_mem_we     <= w_nxt_mem_we;
            r_mem_addr   <= w_nxt_mem_addr;
            r_mem_be     <= w_nxt_mem_be;
            r_mem_wdata  <= w_nxt_mem_wdata;
            r_resp_valid <= w_nxt_resp_valid;
            r_resp_err   <= w_nxt_resp_err;
            r_resp_rdata <= w_nxt_resp_rdata;
`ifdef LSU_MISALIGN_EN
            r_be1        <= w_nxt_be1;
            r_wdata1     <= w_nxt_wdata1;
            r_word0      <= w_nxt_word0;
`endif
        end
    end

    // Core handshake: a request transfers on req_valid & req_ready; responses
    // are single-cycle pulses with no backpressure.
    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_initiator.sv
// Self-checking bench for lsu_initiator: memory responder with programmable
// stalls, expected-transaction and expected-response queues.
module tb_lsu_initiator;
    import lsu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    state_t      o_dbg_state;

    lsu_initiator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_req     (mem_req),
        .mem_gnt     (mem_gnt),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .o_dbg_state (o_dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int resp_seen = 0;
    int rvalid_sent = 0;
    int gnt_stall = 0;
    int rv_stall = 0;

    logic [32:0] exp_q[$];      // {err, rdata}
    int          lat_q[$];
    logic [68:0] exp_mem_q[$];  // {we, addr, be, wdata}
    logic [31:0] rd_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int phase;
        int cnt;
        logic [68:0] held;
        logic [68:0] cur;
        phase = 0;
        cnt = 0;
        held = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            cur = {mem_we, mem_addr, mem_be, mem_wdata};
            if (phase == 2) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                    rvalid_sent++;
                    phase = 0;
                end else cnt--;
            end else if (phase == 1) begin
                check("mem_stable", cur, held);
                cnt--;
            end else if (mem_req) begin
                held = cur;
                cnt = gnt_stall;
                phase = 1;
            end
            if (phase == 1 && cnt == 0) begin
                mem_gnt = 1'b1;
                check("mem_expected", exp_mem_q.size() != 0, 1);
                if (exp_mem_q.size() != 0) check("mem_txn", cur, exp_mem_q.pop_front());
                cnt = rv_stall;
                phase = 2;
            end
        end
    end

    // ---------------- response scoreboard ----------------
    initial begin
        logic [32:0] e;
        int l;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                resp_seen++;
                check("resp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("resp_data", {resp_err, resp_rdata}, e);
                    check("resp_latency", cyc - acc_cyc, l);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bit got;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc = cyc;
                got = 1;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_accept", got, 1);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic err,
                          input logic [31:0] rdata, input int lat);
        int base;
        bit got;
        exp_q.push_back({err, rdata});
        lat_q.push_back(lat);
        base = resp_seen;
        drive(we, f3, addr, wdata);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (resp_seen != base) got = 1;
        end
        check("resp_timeout", got, 1);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] w);
        logic [31:0] r;
        int n;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = w[8*(int'(o)+i) +: 8];
        if (!f3[2] && n < 4) begin
            for (int i = 8*n; i < 32; i++) r[i] = r[8*n-1];
        end
        return r;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int base_rv;
        bit got;
        logic [2:0]  f3;
        logic [1:0]  o;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] w;
        logic        we;
        int n;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_state", o_dbg_state, ST_IDLE);
        rst_n = 1'b1;

        // aligned word load
        exp_mem_q.push_back({1'b0, 32'h10, 4'b1111, 32'h0});
        rd_q.push_back(32'hDEADBEEF);
        do_req(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3);

        // signed and unsigned byte at lane 3
        exp_mem_q.push_back({1'b0, 32'h10, 4'b1000, 32'h0});
        rd_q.push_back(32'h80FF_0000);
        do_req(1'b0, F3_B, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 3);
        exp_mem_q.push_back({1'b0, 32'h10, 4'b1000, 32'h0});
        rd_q.push_back(32'h80FF_0000);
        do_req(1'b0, F3_BU, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 3);

        // halfword store, upper lanes
        exp_mem_q.push_back({1'b1, 32'h20, 4'b1100, 32'hABCD_0000});
        rd_q.push_back(32'h5555_AAAA);
        do_req(1'b1, F3_H, 32'h22, 32'h1234ABCD, 1'b0, 32'h0, 3);

        // misaligned word load across the top of the address space
`ifdef LSU_MISALIGN_EN
        exp_mem_q.push_back({1'b0, 32'hFFFF_FFFC, 4'b1100, 32'h0});
        exp_mem_q.push_back({1'b0, 32'h0000_0000, 4'b0011, 32'h0});
        rd_q.push_back(32'hAABB_0000);
        rd_q.push_back(32'h0000_CCDD);
        do_req(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, 1'b0, 32'hCCDD_AABB, 5);
        exp_mem_q.push_back({1'b1, 32'h100, 4'b1110, 32'h2233_4400});
        exp_mem_q.push_back({1'b1, 32'h104, 4'b0001, 32'h0000_0011});
        rd_q.push_back($urandom);
        rd_q.push_back($urandom);
        do_req(1'b1, F3_W, 32'h101, 32'h1122_3344, 1'b0, 32'h0, 5);
`else
        do_req(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'h0, 1);
        do_req(1'b0, F3_H, 32'h43, 32'h0, 1'b1, 32'h0, 1);
`endif

        // illegal funct3 encodings
        do_req(1'b0, 3'b011, 32'h30, 32'h0, 1'b1, 32'h0, 1);
        do_req(1'b1, F3_BU, 32'h30, 32'h0, 1'b1, 32'h0, 1);

        // grant stall of three cycles
        gnt_stall = 3;
        exp_mem_q.push_back({1'b0, 32'h40, 4'b0011, 32'h0});
        rd_q.push_back(32'h1234_8001);
        do_req(1'b0, F3_HU, 32'h40, 32'h0, 1'b0, 32'h0000_8001, 6);
        gnt_stall = 0;

        // rvalid stall of two cycles
        rv_stall = 2;
        exp_mem_q.push_back({1'b0, 32'h44, 4'b1100, 32'h0});
        rd_q.push_back(32'h8001_1234);
        do_req(1'b0, F3_H, 32'h46, 32'h0, 1'b0, 32'hFFFF_8001, 5);
        rv_stall = 0;

        // randomized aligned traffic
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 4))
                0: f3 = F3_B;
                1: f3 = F3_H;
                2: f3 = F3_W;
                3: f3 = F3_BU;
                default: f3 = F3_HU;
            endcase
            n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            o = 2'($urandom_range(0, 4 - n));
            we = f3[2] ? 1'b0 : 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_FFFC) | {30'b0, o};
            w = $urandom;
            be = '0;
            for (int i = 0; i < 4; i++) be[i] = (i >= int'(o)) && (i < int'(o) + n);
            rd_q.push_back(w);
            if (we) begin
                exp_mem_q.push_back({1'b1, a & 32'hFFFF_FFFC, be, w << (8 * int'(o))});
                do_req(1'b1, f3, a, w, 1'b0, 32'h0, 3);
            end else begin
                exp_mem_q.push_back({1'b0, a & 32'hFFFF_FFFC, be, 32'h0});
                do_req(1'b0, f3, a, 32'h0, 1'b0, model_load(f3, o, w), 3);
            end
        end

        // reset while waiting for read data; the late rvalid must be ignored
        rv_stall = 4;
        exp_mem_q.push_back({1'b0, 32'h50, 4'b1111, 32'h0});
        rd_q.push_back(32'h1111_2222);
        base = resp_seen;
        base_rv = rvalid_sent;
        drive(1'b0, F3_W, 32'h50, 32'h0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_dbg_state == ST_WAIT0) got = 1;
        end
        check("reach_wait0", got, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_state", o_dbg_state, ST_IDLE);
        check("abort_mem_req", mem_req, 0);
        repeat (10) @(negedge clk);
        check("late_rvalid_sent", rvalid_sent, base_rv + 1);
        check("no_resp_after_abort", resp_seen, base);
        check("idle_after_late_rvalid", o_dbg_state, ST_IDLE);
        rv_stall = 0;

        // normal operation after the abort
        exp_mem_q.push_back({1'b0, 32'h60, 4'b0001, 32'h0});
        rd_q.push_back(32'h0000_007F);
        do_req(1'b0, F3_B, 32'h60, 32'h0, 1'b0, 32'h0000_007F, 3);

        repeat (5) @(negedge clk);
        check("resp_q_empty", exp_q.size(), 0);
        check("mem_q_empty", exp_mem_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
